p1500_wsp_driver: RTL and testbench
===================================

Name: p1500_wsp_driver

Overview:
Initiator side of the IEEE P1500 wrapper serial port: drives the control signals the s349 wrapper (WIR, WBY, WBR chain) responds to.
- Takes one command at a time over a valid/ready interface: either an instruction load (WIR) or a data scan (WBY/WBR chain).
- Sequences SelectWIR, CaptureWR, ShiftWR, UpdateWR and the serial input bit.
- Collects the serial output bits and returns them on a response interface.
- Sits between the on-chip test controller or bench and the wrapped core.

Parameters:
- WIR_LEN, 3: instruction register length in bits.
- DATA_MAX, 32: maximum scan length in bits; width of the data and response buses.
- LEN_W, 6: width of the length field; must hold DATA_MAX.

Ports:
- WRCK  input  1  wrapper clock; everything in this block is on the rising edge.
- WRSTN  input  1  asynchronous active-low reset.
- cmd_valid  input  1  a command is offered.
- cmd_ready  output  1  block is able to accept a command.
- cmd_is_ir  input  1  1 = instruction load, 0 = data scan.
- cmd_len  input  LEN_W  number of shift cycles.
- cmd_data  input  DATA_MAX  bits to shift in; bit 0 is sent first.
- rsp_valid  output  1  a response is available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_data  output  DATA_MAX  captured serial-out bits; bit i is from shift cycle i.
- SelectWIR  output  1  to wrapper.
- CaptureWR  output  1  to wrapper.
- ShiftWR  output  1  to wrapper.
- UpdateWR  output  1  to wrapper.
- wsi  output  1  serial data into the wrapper.
- wso  input  1  serial data out of the wrapper.

Behaviour:
- Clock and reset (already decided): one clock, WRCK. WRSTN is asynchronous, active-low.
- Reset values: all outputs are 0, except cmd_ready = 1. State is IDLE, counters and rsp_data are 0. Asserting WRSTN mid-operation aborts the sequence immediately; no UpdateWR pulse follows.
- All outputs are registered.
- State machine: IDLE -> CAPTURE -> SHIFT -> UPDATE -> RESP -> IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_is_ir, the effective length and cmd_data, then go to CAPTURE.
  - The effective length is 3 (WIR_LEN) when cmd_is_ir = 1, otherwise min(cmd_len, DATA_MAX).
- CAPTURE: CaptureWR = 1 for exactly 1 cycle. Go to SHIFT if the effective length > 0, otherwise go to UPDATE.
- SHIFT:
  - ShiftWR = 1 for exactly L cycles, where L is the effective length.
  - In shift cycle i (i = 0..L-1), wsi = cmd_data[i].
  - At the rising edge ending cycle i, sample wso into rsp_data[i].
  - Bits of rsp_data at positions >= L are 0.
  - After the last shift cycle, go to UPDATE.
- UPDATE: UpdateWR = 1 for exactly 1 cycle, then go to RESP.
- Select and control rules:
  - SelectWIR equals the latched cmd_is_ir from CAPTURE through UPDATE, and is 0 in IDLE and RESP.
  - CaptureWR, ShiftWR and UpdateWR are mutually exclusive (one-hot or all zero).
  - wsi is 0 whenever ShiftWR = 0.
- RESP:
  - rsp_valid = 1 and rsp_data is stable while rsp_valid is held.
  - On rsp_ready, go to IDLE; cmd_ready is 1 in the following cycle.
  - Back-pressure is unbounded: the block stays in RESP indefinitely.
- Latency: from command accept to rsp_valid is L + 3 cycles (1 IDLE->CAPTURE, 1 CAPTURE, L SHIFT, 1 UPDATE).
- Command acceptance:
  - cmd_ready = 0 in every state other than IDLE; cmd_valid is ignored there.
  - There is no command buffering.
- Length handling:
  - cmd_len > DATA_MAX is clamped to DATA_MAX.
  - cmd_len = 0 on a data scan gives a capture and an update with no shift (used to apply a pattern held in the chain).
  - For instruction loads, cmd_len is ignored.
- Shift counter: LEN_W bits, counts down from L to 0, no wrap.

Decomposition:
- Package p1500_pkg holds:
  - Instruction opcodes: WS_BYPASS = 3'b000, WS_EXTEST = 3'b001, WS_INTEST = 3'b010, WS_PRELOAD = 3'b011.
  - The state enum: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
  - WIR_LEN.
- No sub-module. The shift/capture datapath is a counter plus an indexed register inside this module.

Test Plan:
- Reset mid-SHIFT (WRSTN low for 1 cycle during cycle 2 of 5):
  - All control outputs and wsi go to 0 asynchronously.
  - cmd_ready = 1, rsp_valid = 0.
  - No UpdateWR pulse.
- Instruction load, cmd_is_ir = 1, cmd_data = 3'b010 (WS_INTEST), with a bench WIR model:
  - Sequence is CaptureWR 1 cycle, ShiftWR 3 cycles, UpdateWR 1 cycle, with SelectWIR = 1 throughout.
  - wsi is 0, 1, 0.
  - The model WIR holds 3'b010; rsp_valid appears 6 cycles after accept.
- Data scan, cmd_len = 20, cmd_data = 32'h000A5A5A, through a 20-bit loopback chain preloaded with 20'hFFFFF:
  - rsp_data = 32'h000FFFFF.
  - A second identical scan returns 32'h000A5A5A.
- Bypass scan with WBY, cmd_len = 4, cmd_data = 4'b1011:
  - rsp_data[3:0] = {0, 1, 1, X0}, where X0 is the prior bypass value, i.e. a 1-cycle delay.
- cmd_len = 0 data scan:
  - CaptureWR and UpdateWR on consecutive cycles, ShiftWR never asserted.
  - rsp_data = 0.
- cmd_len = 40 (clamp) with rsp_ready held low for 10 cycles:
  - Exactly 32 ShiftWR cycles.
  - rsp_valid and rsp_data stay stable for the whole stall.
  - cmd_valid offered during the stall is not accepted (cmd_ready = 0).

Source files
------------

// File: rtl/p1500_pkg.sv
// Shared definitions for the P1500 wrapper serial port driver.
// Holds WIR opcodes, the instruction length and the sequencer states.
package p1500_pkg;

    localparam int WIR_LEN = 3;

    localparam logic [WIR_LEN-1:0] WS_BYPASS  = 3'b000;
    localparam logic [WIR_LEN-1:0] WS_EXTEST  = 3'b001;
    localparam logic [WIR_LEN-1:0] WS_INTEST  = 3'b010;
    localparam logic [WIR_LEN-1:0] WS_PRELOAD = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE,
        RESP
    } state_e;

endpackage

// File: rtl/p1500_wsp_driver.sv
// Initiator for the P1500 wrapper serial port: sequences capture,
// shift and update for one WIR load or data scan per command.
module p1500_wsp_driver
    import p1500_pkg::*;
#(
    parameter int DATA_MAX = 32,
    parameter int LEN_W    = 6
) (
    input  logic                WRCK,
    input  logic                WRSTN,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_is_ir,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_MAX-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_MAX-1:0] rsp_data,
    output logic                SelectWIR,
    output logic                CaptureWR,
    output logic                ShiftWR,
    output logic                UpdateWR,
    output logic                wsi,
    input  logic                wso
);

    localparam int IDX_W = $clog2(DATA_MAX);

    state_e              state_q;
    logic                is_ir_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [DATA_MAX-1:0] data_q;
    logic [DATA_MAX-1:0] rsp_data_q;
    logic                cmd_ready_q;
    logic                rsp_valid_q;
    logic                sel_q;
    logic                cap_q;
    logic                shift_q;
    logic                upd_q;
    logic                wsi_q;

    logic [LEN_W-1:0]    len_d;
    logic [IDX_W-1:0]    idx;

    always_comb begin
        len_d = cmd_len;
        if (cmd_is_ir) begin
            len_d = LEN_W'(WIR_LEN);
        end else if (cmd_len > LEN_W'(DATA_MAX)) begin
            len_d = LEN_W'(DATA_MAX);
        end
    end

    // cnt_q holds the shifts still to go, so this is the current bit
    assign idx = IDX_W'(len_q - cnt_q);

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state_q     <= IDLE;
            is_ir_q     <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            sel_q       <= 1'b0;
            cap_q       <= 1'b0;
            shift_q     <= 1'b0;
            upd_q       <= 1'b0;
            wsi_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        is_ir_q     <= cmd_is_ir;
                        len_q       <= len_d;
                        cnt_q       <= len_d;
                        data_q      <= cmd_data;
                        rsp_data_q  <= '0;
                        cmd_ready_q <= 1'b0;
                        sel_q       <= cmd_is_ir;
                        cap_q       <= 1'b1;
                        state_q     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    cap_q <= 1'b0;
                    if (cnt_q != '0) begin
                        shift_q <= 1'b1;
                        wsi_q   <= data_q[0];
                        data_q  <= data_q >> 1;
                        state_q <= SHIFT;
                    end else begin
                        upd_q   <= 1'b1;
                        state_q <= UPDATE;
                    end
                end
                SHIFT: begin
                    rsp_data_q[idx] <= wso;
                    cnt_q           <= cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        shift_q <= 1'b0;
                        wsi_q   <= 1'b0;
                        upd_q   <= 1'b1;
                        state_q <= UPDATE;
                    end else begin
                        wsi_q  <= data_q[0];
                        data_q <= data_q >> 1;
                    end
                end
                UPDATE: begin
                    upd_q       <= 1'b0;
                    sel_q       <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SelectWIR = sel_q;
    assign CaptureWR = cap_q;
    assign ShiftWR   = shift_q;
    assign UpdateWR  = upd_q;
    assign wsi       = wsi_q;

    logic unused_ok;
    assign unused_ok = is_ir_q;

endmodule

// File: tb/tb_p1500_wsp_driver.sv
// Directed bench for p1500_wsp_driver with small WIR, WBY and
// 20-bit boundary chain models on the serial port.
module tb_p1500_wsp_driver;
    import p1500_pkg::*;

    logic        WRCK;
    logic        WRSTN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_ir;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        SelectWIR;
    logic        CaptureWR;
    logic        ShiftWR;
    logic        UpdateWR;
    logic        wsi;
    logic        wso;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic        mdl_init;
    logic        use_byp;
    logic [19:0] mdl_chain;
    logic [2:0]  wir;
    logic [2:0]  wir_upd;
    logic        wby;
    logic [19:0] chain;

    p1500_wsp_driver #(
        .DATA_MAX(32),
        .LEN_W   (6)
    ) dut (
        .WRCK     (WRCK),
        .WRSTN    (WRSTN),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_is_ir(cmd_is_ir),
        .cmd_len  (cmd_len),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .SelectWIR(SelectWIR),
        .CaptureWR(CaptureWR),
        .ShiftWR  (ShiftWR),
        .UpdateWR (UpdateWR),
        .wsi      (wsi),
        .wso      (wso)
    );

    initial WRCK = 1'b0;
    always #5 WRCK = ~WRCK;

    always @(posedge WRCK) begin
        if (mdl_init) begin
            wir     <= '0;
            wir_upd <= '0;
            wby     <= 1'b0;
            chain   <= mdl_chain;
        end else begin
            if (ShiftWR && SelectWIR) wir <= {wsi, wir[2:1]};
            if (UpdateWR && SelectWIR) wir_upd <= wir;
            if (ShiftWR && !SelectWIR && use_byp) wby <= wsi;
            if (ShiftWR && !SelectWIR && !use_byp)
                chain <= {wsi, chain[19:1]};
        end
    end

    assign wso = SelectWIR ? wir[0] : (use_byp ? wby : chain[0]);

    task automatic load_chain(input logic [19:0] v);
        @(negedge WRCK);
        mdl_chain = v;
        mdl_init  = 1'b1;
        @(negedge WRCK);
        mdl_init  = 1'b0;
    endtask

    task automatic run_cmd(
        input  logic        is_ir,
        input  logic [5:0]  len,
        input  logic [31:0] data,
        input  int          stall,
        output int          ncap,
        output int          nshift,
        output int          nupd,
        output int          cap_at,
        output int          upd_at,
        output int          lat,
        output logic [31:0] rsp,
        output logic [31:0] wbits,
        output int          bad,
        output int          stall_bad,
        output int          busy_bad,
        output logic        rdy_after
    );
        int n;
        ncap = 0; nshift = 0; nupd = 0;
        cap_at = -1; upd_at = -1; lat = -1;
        rsp = '0; wbits = '0;
        bad = 0; stall_bad = 0; busy_bad = 0;
        rdy_after = 1'b0;
        n = 0;
        @(negedge WRCK);
        cmd_valid = 1'b1;
        cmd_is_ir = is_ir;
        cmd_len   = len;
        cmd_data  = data;
        while (lat < 0 && n < 200) begin
            @(negedge WRCK);
            n++;
            cmd_valid = 1'b0;
            if (CaptureWR) begin ncap++; cap_at = n; end
            if (UpdateWR) begin nupd++; upd_at = n; end
            if (ShiftWR) begin
                if (nshift < 32) wbits[nshift] = wsi;
                nshift++;
            end
            if (int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR) > 1)
                bad++;
            if (!ShiftWR && wsi) bad++;
            if ((CaptureWR || ShiftWR || UpdateWR) && SelectWIR !== is_ir)
                bad++;
            if (rsp_valid) begin
                lat = n;
                rsp = rsp_data;
            end
        end
        if (lat >= 0) begin
            rsp_ready = 1'b0;
            for (int k = 0; k < stall; k++) begin
                cmd_valid = 1'b1;
                @(negedge WRCK);
                if (!rsp_valid || rsp_data !== rsp) stall_bad++;
                if (cmd_ready || CaptureWR) busy_bad++;
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
            @(negedge WRCK);
            rsp_ready = 1'b0;
            rdy_after = cmd_ready && !rsp_valid;
        end
    endtask

    task automatic test_reset();
        total_cnt++;
        if (cmd_ready !== 1'b1)
            $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_valid !== 1'b0)
            $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if ({SelectWIR, CaptureWR, ShiftWR, UpdateWR} !== 4'b0)
            $display("FAIL reset_ctrl got %b want 0000",
                     {SelectWIR, CaptureWR, ShiftWR, UpdateWR});
        else pass_cnt++;
        total_cnt++;
        if (wsi !== 1'b0)
            $display("FAIL reset_wsi got %b want 0", wsi);
        else pass_cnt++;
        total_cnt++;
        if (rsp_data !== 32'h0)
            $display("FAIL reset_rsp_data got %h want 0", rsp_data);
        else pass_cnt++;
    endtask

    task automatic test_ir_load();
        int nc, ns, nu, ca, ua, lat, bad, sb, bb;
        logic [31:0] rsp, wb;
        logic ra;
        run_cmd(1'b1, 6'd7, {29'b0, WS_INTEST}, 0,
                nc, ns, nu, ca, ua, lat, rsp, wb, bad, sb, bb, ra);
        total_cnt++;
        if (nc != 1 || ns != 3 || nu != 1)
            $display("FAIL ir_pulses got c%0d s%0d u%0d want c1 s3 u1",
                     nc, ns, nu);
        else pass_cnt++;
        total_cnt++;
        if (ca != 1 || ua != 5)
            $display("FAIL ir_order got cap@%0d upd@%0d want 1 5", ca, ua);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0)
            $display("FAIL ir_select_rules got %0d errors want 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (wb[2:0] !== 3'b010)
            $display("FAIL ir_wsi got %b want 010", wb[2:0]);
        else pass_cnt++;
        total_cnt++;
        if (wir_upd !== WS_INTEST)
            $display("FAIL ir_wir got %b want %b", wir_upd, WS_INTEST);
        else pass_cnt++;
        total_cnt++;
        if (lat != 6)
            $display("FAIL ir_latency got %0d want 6", lat);
        else pass_cnt++;
        total_cnt++;
        if (ra !== 1'b1)
            $display("FAIL ir_ready_after got %b want 1", ra);
        else pass_cnt++;
    endtask

    task automatic test_chain();
        int nc, ns, nu, ca, ua, lat, bad, sb, bb;
        logic [31:0] rsp, wb;
        logic ra;
        use_byp = 1'b0;
        load_chain(20'hFFFFF);
        run_cmd(1'b0, 6'd20, 32'h000A5A5A, 0,
                nc, ns, nu, ca, ua, lat, rsp, wb, bad, sb, bb, ra);
        total_cnt++;
        if (rsp !== 32'h000FFFFF)
            $display("FAIL chain1_rsp got %h want 000fffff", rsp);
        else pass_cnt++;
        total_cnt++;
        if (ns != 20 || lat != 23)
            $display("FAIL chain1_timing got s%0d lat%0d want 20 23",
                     ns, lat);
        else pass_cnt++;
        total_cnt++;
        if (wb !== 32'h000A5A5A)
            $display("FAIL chain1_wsi got %h want 000a5a5a", wb);
        else pass_cnt++;
        run_cmd(1'b0, 6'd20, 32'h000A5A5A, 0,
                nc, ns, nu, ca, ua, lat, rsp, wb, bad, sb, bb, ra);
        total_cnt++;
        if (rsp !== 32'h000A5A5A)
            $display("FAIL chain2_rsp got %h want 000a5a5a", rsp);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0)
            $display("FAIL chain2_rules got %0d errors want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        int nc, ns, nu, ca, ua, lat, bad, sb, bb;
        logic [31:0] rsp, wb;
        logic ra, x0;
        use_byp = 1'b1;
        @(negedge WRCK);
        x0 = wby;
        run_cmd(1'b0, 6'd4, 32'h0000000B, 0,
                nc, ns, nu, ca, ua, lat, rsp, wb, bad, sb, bb, ra);
        total_cnt++;
        if (rsp !== {28'b0, 3'b011, x0})
            $display("FAIL bypass_rsp got %h want %h",
                     rsp, {28'b0, 3'b011, x0});
        else pass_cnt++;
        total_cnt++;
        if (ns != 4 || lat != 7)
            $display("FAIL bypass_timing got s%0d lat%0d want 4 7", ns, lat);
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        int nc, ns, nu, ca, ua, lat, bad, sb, bb;
        logic [31:0] rsp, wb;
        logic ra;
        use_byp = 1'b0;
        run_cmd(1'b0, 6'd0, 32'hFFFFFFFF, 0,
                nc, ns, nu, ca, ua, lat, rsp, wb, bad, sb, bb, ra);
        total_cnt++;
        if (nc != 1 || ns != 0 || nu != 1)
            $display("FAIL len0_pulses got c%0d s%0d u%0d want c1 s0 u1",
                     nc, ns, nu);
        else pass_cnt++;
        total_cnt++;
        if (ua != ca + 1)
            $display("FAIL len0_adjacent got cap@%0d upd@%0d want gap 1",
                     ca, ua);
        else pass_cnt++;
        total_cnt++;
        if (rsp !== 32'h0)
            $display("FAIL len0_rsp got %h want 0", rsp);
        else pass_cnt++;
        total_cnt++;
        if (lat != 3)
            $display("FAIL len0_latency got %0d want 3", lat);
        else pass_cnt++;
        total_cnt++;
        if (bad != 0)
            $display("FAIL len0_rules got %0d errors want 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_clamp_stall();
        int nc, ns, nu, ca, ua, lat, bad, sb, bb;
        logic [31:0] rsp, wb, d, exp;
        logic ra, x0;
        use_byp = 1'b1;
        d = 32'hDEADBEEF;
        @(negedge WRCK);
        x0 = wby;
        exp = {d[30:0], x0};
        run_cmd(1'b0, 6'd40, d, 10,
                nc, ns, nu, ca, ua, lat, rsp, wb, bad, sb, bb, ra);
        total_cnt++;
        if (ns != 32)
            $display("FAIL clamp_shifts got %0d want 32", ns);
        else pass_cnt++;
        total_cnt++;
        if (lat != 35)
            $display("FAIL clamp_latency got %0d want 35", lat);
        else pass_cnt++;
        total_cnt++;
        if (rsp !== exp)
            $display("FAIL clamp_rsp got %h want %h", rsp, exp);
        else pass_cnt++;
        total_cnt++;
        if (sb != 0)
            $display("FAIL stall_stable got %0d errors want 0", sb);
        else pass_cnt++;
        total_cnt++;
        if (bb != 0)
            $display("FAIL stall_no_accept got %0d errors want 0", bb);
        else pass_cnt++;
        total_cnt++;
        if (ra !== 1'b1)
            $display("FAIL stall_ready_after got %b want 1", ra);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_shift();
        int extra;
        use_byp = 1'b0;
        @(negedge WRCK);
        cmd_valid = 1'b1;
        cmd_is_ir = 1'b0;
        cmd_len   = 6'd5;
        cmd_data  = 32'h0000001F;
        @(negedge WRCK);
        cmd_valid = 1'b0;
        @(negedge WRCK);
        @(negedge WRCK);
        total_cnt++;
        if (ShiftWR !== 1'b1)
            $display("FAIL rst_mid_in_shift got %b want 1", ShiftWR);
        else pass_cnt++;
        WRSTN = 1'b0;
        #1;
        total_cnt++;
        if ({SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi} !== 5'b0)
            $display("FAIL rst_mid_ctrl got %b want 00000",
                     {SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi});
        else pass_cnt++;
        total_cnt++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL rst_mid_hs got rdy%b vld%b want rdy1 vld0",
                     cmd_ready, rsp_valid);
        else pass_cnt++;
        @(negedge WRCK);
        WRSTN = 1'b1;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge WRCK);
            if (UpdateWR || ShiftWR || CaptureWR || rsp_valid) extra++;
        end
        total_cnt++;
        if (extra != 0)
            $display("FAIL rst_mid_no_update got %0d pulses want 0", extra);
        else pass_cnt++;
        total_cnt++;
        if (cmd_ready !== 1'b1)
            $display("FAIL rst_mid_idle got %b want 1", cmd_ready);
        else pass_cnt++;
    endtask

    initial begin
        WRSTN     = 1'b0;
        cmd_valid = 1'b0;
        cmd_is_ir = 1'b0;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        use_byp   = 1'b0;
        mdl_init  = 1'b1;
        mdl_chain = '0;
        repeat (3) @(negedge WRCK);
        test_reset();
        WRSTN    = 1'b1;
        mdl_init = 1'b0;
        @(negedge WRCK);
        test_ir_load();
        test_chain();
        test_bypass();
        test_len_zero();
        test_clamp_stall();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
